// File: rtl/main_dec.sv
// LEGv8 main control decoder: combinational control outputs plus a sticky illegal-opcode flag.
// Optional ADDI decode is enabled by defining MAINDEC_ADDI_EN.
module main_dec (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] Op,
    input  logic        OpValid,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [1:0]  ALUOp,
    output logic        Illegal,
    output logic        IllegalSeen
);

    logic [8:0] ctrl;

    // Equality tests (not casez) so X/Z on Op falls through to the illegal default.
    always_comb begin
        ctrl    = '0;
        Illegal = 1'b1;
        if (Op == 11'b111_1100_0010) begin
            ctrl    = 9'b0_1_1_1_1_0_0_00;
            Illegal = 1'b0;
        end else if (Op == 11'b111_1100_0000) begin
            ctrl    = 9'b1_1_0_0_0_1_0_00;
            Illegal = 1'b0;
        end else if (Op[10:3] == 8'b1011_0100) begin
            ctrl    = 9'b1_0_0_0_0_0_1_01;
            Illegal = 1'b0;
        end else if (Op == 11'b100_0101_1000 || Op == 11'b110_0101_1000 ||
                     Op == 11'b100_0101_0000 || Op == 11'b101_0101_0000) begin
            ctrl    = 9'b0_0_0_1_0_0_0_10;
            Illegal = 1'b0;
`ifdef MAINDEC_ADDI_EN
        end else if (Op[10:1] == 10'b100_1000_100) begin
            ctrl    = 9'b0_1_0_1_0_0_0_00;
            Illegal = 1'b0;
`else
`endif
        end
    end

    assign {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp} = ctrl;

    always_ff @(posedge clk) begin
        if (!reset_n)
            IllegalSeen <= 1'b0;
        else if (OpValid && Illegal)
            IllegalSeen <= 1'b1;
    end

endmodule

// File: tb/tb_main_dec.sv
// Self-checking bench for main_dec: directed cases plus random opcodes against a mask/value table model.
module tb_main_dec;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] Op;
    logic        OpValid;
    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]  ALUOp;
    logic        Illegal, IllegalSeen;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        seen_m = 1'b0;

    typedef struct {
        logic [10:0] val;
        logic [10:0] mask;
        logic [8:0]  vec;
    } entry_t;
    entry_t tbl[$];

    main_dec dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .OpValid(OpValid),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
        .Illegal(Illegal), .IllegalSeen(IllegalSeen)
    );

    always #5 clk = ~clk;

    // Returns {illegal, control vector}.
    function automatic logic [9:0] ref_dec(input logic [10:0] op);
        if ($isunknown(op))
            return {1'b1, 9'b0};
        foreach (tbl[i])
            if ((op & tbl[i].mask) == tbl[i].val)
                return {1'b0, tbl[i].vec};
        return {1'b1, 9'b0};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [10:0] op, input logic valid, input logic rst);
        logic [9:0] e;
        @(negedge clk);
        Op = op; OpValid = valid; reset_n = rst;
        #1;
        e = ref_dec(op);
        check("ctrl", {7'b0, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp},
              {7'b0, e[8:0]});
        check("illegal", {15'b0, Illegal}, {15'b0, e[9]});
        @(posedge clk);
        if (!rst) seen_m = 1'b0;
        else if (valid && e[9]) seen_m = 1'b1;
        #1;
        check("seen", {15'b0, IllegalSeen}, {15'b0, seen_m});
    endtask

    initial begin
        logic [10:0] op;
        int unsigned k;
        tbl.push_back('{11'b111_1100_0010, 11'h7FF, 9'b011110000});
        tbl.push_back('{11'b111_1100_0000, 11'h7FF, 9'b110001000});
        tbl.push_back('{11'b101_1010_0000, 11'h7F8, 9'b100000101});
        tbl.push_back('{11'b100_0101_1000, 11'h7FF, 9'b000100010});
        tbl.push_back('{11'b110_0101_1000, 11'h7FF, 9'b000100010});
        tbl.push_back('{11'b100_0101_0000, 11'h7FF, 9'b000100010});
        tbl.push_back('{11'b101_0101_0000, 11'h7FF, 9'b000100010});
`ifdef MAINDEC_ADDI_EN
        tbl.push_back('{11'b100_1000_1000, 11'h7FE, 9'b010100000});
`else
`endif
        Op = '0; OpValid = 1'b0; reset_n = 1'b0;

        apply(11'b000_0000_0000, 1'b1, 1'b0);
        apply(11'b000_0000_0000, 1'b1, 1'b0);
        apply(11'b000_0000_0000, 1'b0, 1'b1);   // illegal but unqualified
        apply(11'b111_1100_0010, 1'b0, 1'b1);
        apply(11'b111_1100_0000, 1'b1, 1'b1);
        apply(11'b101_1010_0000, 1'b1, 1'b1);
        apply(11'b101_1010_0111, 1'b1, 1'b1);
        apply(11'b100_0101_1000, 1'b1, 1'b1);
        apply(11'b110_0101_1000, 1'b1, 1'b1);
        apply(11'b100_0101_0000, 1'b1, 1'b1);
        apply(11'b101_0101_0000, 1'b1, 1'b1);
        apply(11'b100_1000_1000, 1'b0, 1'b1);
        apply(11'b100_1000_1001, 1'b0, 1'b1);
        apply(11'bxxx_xxxx_xxxx, 1'b0, 1'b1);
        apply(11'b101_1010_1010, 1'b1, 1'b1);   // CBNZ sets the sticky flag
        apply(11'b111_1100_0010, 1'b1, 1'b1);   // stays set
        apply(11'b111_1111_1111, 1'b1, 1'b1);
        apply(11'b111_1111_1111, 1'b1, 1'b0);   // reset beats simultaneous set
        apply(11'b000_0000_0000, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                op = 11'($urandom);
            end else begin
                k  = $urandom_range(0, tbl.size() - 1);
                op = tbl[k].val | (11'($urandom) & ~tbl[k].mask);
            end
            apply(op, 1'($urandom), ($urandom_range(0, 15) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_dec.md
# main_dec

Main control decoder for the single-cycle LEGv8 datapath. Decodes the 11-bit instruction opcode field (Instr[31:21]) into datapath control signals: register-read source select, ALU operand select, writeback select, register/memory enables, branch, and the 2-bit ALUOp consumed by the ALU decoder. Control outputs are purely combinational. A clocked sticky flag records any qualified unsupported opcode for debug and trap logic.

## Interface
- No parameters.
- clk  in  1  system clock; rising edge used.
- reset_n  in  1  synchronous, active-low reset; one clock, one reset domain.
- Op  in  11  opcode field Instr[31:21].
- OpValid  in  1  Op holds a real fetched instruction this cycle; qualifies the sticky flag only.
- Reg2Loc  out  1  1: read-register-2 address from Instr[4:0]; 0: from Instr[20:16].
- ALUSrc  out  1  1: ALU operand B is the sign-extended immediate; 0: register.
- MemtoReg  out  1  1: writeback data from data memory; 0: from ALU.
- RegWrite  out  1  register file write enable.
- MemRead  out  1  data memory read enable.
- MemWrite  out  1  data memory write enable.
- Branch  out  1  conditional branch (CBZ).
- ALUOp  out  2  00 add, 01 pass/compare-B, 10 use funct (R-type).
- Illegal  out  1  combinational: Op matches no supported opcode.
- IllegalSeen  out  1  registered sticky flag.

## Operation
- Output vector order {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]}.
- LDUR, Op = 111_1100_0010 -> 0_1_1_1_1_0_0_00.
- STUR, Op = 111_1100_0000 -> 1_1_0_0_0_1_0_00.
- CBZ, Op = 101_1010_0xxx (low 3 bits don't care) -> 1_0_0_0_0_0_1_01.
- R-type ADD 100_0101_1000, SUB 110_0101_1000, AND 100_0101_0000, ORR 101_0101_0000 -> 0_0_0_1_0_0_0_10.
- Any other Op (including CBNZ 101_1010_1xxx, all-ones, all-zeros) -> all control outputs 0, Illegal = 1.
- Illegal = 0 for every supported opcode.
- Decode is exact-match on all specified bits; X/Z on Op drives defined defaults (all-zero controls, Illegal = 1). Outputs are never X.
- IllegalSeen: set when OpValid && Illegal at a clock edge; held until reset. OpValid does not affect control outputs.

## Timing
- Control outputs and Illegal: combinational, zero-cycle latency from Op. No dependence on clk or reset_n.
- IllegalSeen: updates on rising clk. reset_n low at an edge -> 0; reset has priority over a simultaneous set.
- IllegalSeen reset value 0; after reset release, first possible set is the first edge with OpValid && Illegal.
- Once set, supported opcodes do not clear IllegalSeen; only reset_n clears it.

## Configuration
- MAINDEC_ADDI_EN defined: additionally decodes ADDI, Op = 100_1000_100x -> 0_1_0_1_0_0_0_00, Illegal = 0.
- MAINDEC_ADDI_EN undefined: ADDI opcodes are unsupported (all-zero controls, Illegal = 1).

## Test plan
- Apply Op 111_1100_0010, wait 1 time unit -> vector 011110000, Illegal 0. Apply 111_1100_0000 -> 110001000.
- Apply CBZ 101_1010_0000 and 101_1010_0111 -> 100000101. Apply CBNZ 101_1010_1010 -> 000000000, Illegal 1.
- Apply ADD/SUB/AND/ORR opcodes -> 000100010. Apply 111_1111_1111 and 000_0000_0000 -> 000000000, Illegal 1.
- Hold reset_n = 0 for 2 edges -> IllegalSeen 0. Release reset_n, apply Op 000_0000_0000 with OpValid 0 -> IllegalSeen stays 0. Set OpValid 1 -> IllegalSeen 1 after the next edge. Then apply LDUR -> IllegalSeen remains 1.
- With reset_n = 0, OpValid 1 and an illegal Op at the same edge -> IllegalSeen 0 (reset wins).
- Apply Op 100_1000_1000 -> 010100000 with MAINDEC_ADDI_EN defined; 000000000 and Illegal 1 without it.
